// File: rtl/fpu_host_if_if.sv
// CPU-side 8-bit host bus of the FPU: strobes, address and data, plus the command-end handshake.
interface fpu_host_if_if;
    logic [7:0] databus_in;
    logic [7:0] databus_out;
    logic [3:0] addr;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       end_ack;
    logic       cmd_end;
    logic       busy;

    modport master (
        output databus_in, addr, cs, rd, wr, end_ack,
        input  databus_out, cmd_end, busy
    );

    modport slave (
        input  databus_in, addr, cs, rd, wr, end_ack,
        output databus_out, cmd_end, busy
    );
endinterface

// File: rtl/fpu_host_if.sv
// Host-port responder for the FPU: operand/op-code/result registers, write-strobe decode
// and the start / cmd_end / end_ack command sequencer in front of the arithmetic core.
module fpu_host_if #(
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            arst,
    fpu_host_if_if.slave    bus,
    output logic            core_start,
    output logic [OP_W-1:0] core_op,
    output logic [31:0]     core_a,
    output logic [31:0]     core_b,
    input  logic            core_done,
    input  logic [31:0]     core_result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [31:0]    QNAN    = 32'h7FC0_0000;

    logic [1:0]      state_q, state_d;
    logic            wr_q, wr_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [31:0]     res_q, res_d;
    logic            ovr_q, ovr_d;
    logic            start_q, start_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            wr_commit;
    logic            locked;
    logic [7:0]      rdata;

    // wr_q remembers the previous sampled strobe level, so a long low strobe commits once.
    assign wr_commit = !bus.cs && !bus.wr && wr_q;
    assign locked    = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        wr_d    = bus.wr;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        ovr_d   = ovr_q;
        start_d = 1'b0;
        cnt_d   = cnt_q;

        if (wr_commit) begin
            if (bus.addr == 4'hD) begin
                ovr_d = 1'b0;
            end else if (bus.addr <= 4'd9) begin
                if (locked) begin
                    ovr_d = 1'b1;
                end else if (bus.addr < 4'd4) begin
                    a_d[{bus.addr[1:0], 3'b000} +: 8] = bus.databus_in;
                end else if (bus.addr < 4'd8) begin
                    b_d[{bus.addr[1:0], 3'b000} +: 8] = bus.databus_in;
                end else if (bus.addr == 4'd8) begin
                    op_d = bus.databus_in[OP_W-1:0];
                end
            end
        end

        // Sequencer runs after the write decode so a timeout's ovr set beats a same-cycle clear.
        case (state_q)
            S_IDLE: begin
                if (wr_commit && bus.addr == 4'd9) begin
                    start_d = 1'b1;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (core_done) begin
                    res_d   = core_result;
                    state_d = S_DONE;
                end else if (TIMEOUT > 0) begin
                    if (cnt_q == TO_LAST) begin
                        res_d   = QNAN;
                        ovr_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.end_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            ovr_q   <= 1'b0;
            start_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            ovr_q   <= ovr_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (!bus.cs && !bus.rd) begin
            case (bus.addr)
                4'h0, 4'h1, 4'h2, 4'h3: rdata = a_q[{bus.addr[1:0], 3'b000} +: 8];
                4'h4, 4'h5, 4'h6, 4'h7: rdata = b_q[{bus.addr[1:0], 3'b000} +: 8];
                4'h8:    rdata = 8'(op_q);
                4'h9:    rdata = res_q[7:0];
                4'hA:    rdata = res_q[15:8];
                4'hB:    rdata = res_q[23:16];
                4'hC:    rdata = res_q[31:24];
                4'hD:    rdata = {5'b0, ovr_q, state_q == S_DONE, state_q == S_RUN};
                default: rdata = 8'h00;
            endcase
        end
    end

    assign bus.databus_out = rdata;
    assign bus.busy        = (state_q == S_RUN);
    assign bus.cmd_end     = (state_q == S_DONE);
    assign core_start      = start_q;
    assign core_op         = op_q;
    assign core_a          = a_q;
    assign core_b          = b_q;

endmodule

// File: tb/tb_fpu_host_if.sv
// Bench for fpu_host_if: directed host-port scenarios with literal expectations, then random
// bus/core traffic, all cross-checked every cycle against a behavioural model of the port.
module tb_fpu_host_if;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        core_done;
    logic [31:0] core_result;
    logic        core_start;
    logic [3:0]  core_op;
    logic [31:0] core_a, core_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic chk_en = 1'b0;

    fpu_host_if_if hif();

    fpu_host_if #(.OP_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .arst(arst), .bus(hif),
        .core_start(core_start), .core_op(core_op),
        .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    // Model: operands as byte arrays, mode 0=idle 1=running 2=finished, age = cycles spent running.
    logic [7:0]  m_a[4];
    logic [7:0]  m_b[4];
    logic [3:0]  m_op;
    logic [31:0] m_res;
    int          m_mode;
    int          m_age;
    logic        m_ovr, m_wrp, m_start;
    logic        m_strobe;

    assign m_strobe = !hif.cs && !hif.wr && m_wrp;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < 4; i++) begin m_a[i] <= 8'h00; m_b[i] <= 8'h00; end
            m_op <= 4'h0; m_res <= 32'h0; m_mode <= 0; m_age <= 0;
            m_ovr <= 1'b0; m_wrp <= 1'b0; m_start <= 1'b0;
        end else begin
            m_wrp   <= hif.wr;
            m_start <= 1'b0;
            if (m_strobe) begin
                if (hif.addr == 4'hD) m_ovr <= 1'b0;
                else if (hif.addr <= 4'd9 && m_mode != 0) m_ovr <= 1'b1;
                else if (hif.addr < 4'd4) m_a[hif.addr[1:0]] <= hif.databus_in;
                else if (hif.addr < 4'd8) m_b[hif.addr[1:0]] <= hif.databus_in;
                else if (hif.addr == 4'd8) m_op <= hif.databus_in[3:0];
            end
            if (m_mode == 0) begin
                if (m_strobe && hif.addr == 4'd9) begin
                    m_mode <= 1; m_start <= 1'b1; m_res <= 32'h0; m_age <= 0;
                end
            end else if (m_mode == 1) begin
                if (core_done) begin
                    m_res <= core_result; m_mode <= 2;
                end else if (m_age + 1 == TO) begin
                    m_res <= 32'h7FC00000; m_ovr <= 1'b1; m_mode <= 2;
                end else begin
                    m_age <= m_age + 1;
                end
            end else begin
                if (hif.end_ack) m_mode <= 0;
            end
        end
    end

    function automatic logic [7:0] exp_rd();
        if (hif.cs || hif.rd) return 8'h00;
        case (hif.addr)
            4'h0, 4'h1, 4'h2, 4'h3: return m_a[hif.addr[1:0]];
            4'h4, 4'h5, 4'h6, 4'h7: return m_b[hif.addr[1:0]];
            4'h8: return {4'h0, m_op};
            4'h9: return m_res[7:0];
            4'hA: return m_res[15:8];
            4'hB: return m_res[23:16];
            4'hC: return m_res[31:24];
            4'hD: return {5'b0, m_ovr, m_mode == 2, m_mode == 1};
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en && !arst) begin
            chk("m_dbus",   {24'h0, hif.databus_out}, {24'h0, exp_rd()});
            chk("m_busy",   {31'h0, hif.busy},    {31'h0, m_mode == 1});
            chk("m_cmdend", {31'h0, hif.cmd_end}, {31'h0, m_mode == 2});
            chk("m_start",  {31'h0, core_start},  {31'h0, m_start});
            chk("m_core_a", core_a, {m_a[3], m_a[2], m_a[1], m_a[0]});
            chk("m_core_b", core_b, {m_b[3], m_b[2], m_b[1], m_b[0]});
            chk("m_core_op", {28'h0, core_op}, {28'h0, m_op});
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wr_byte(input logic [3:0] a, input logic [7:0] d, input int hold = 1);
        hif.wr = 1'b1; hif.cs = 1'b1;
        cyc(1);
        hif.cs = 1'b0; hif.addr = a; hif.databus_in = d; hif.wr = 1'b0;
        cyc(hold);
        hif.wr = 1'b1; hif.cs = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        hif.cs = 1'b0; hif.rd = 1'b0; hif.addr = a;
        #1;
        chk(name, {24'h0, hif.databus_out}, {24'h0, exp});
        hif.rd = 1'b1; hif.cs = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] ab[4];
        logic [7:0] rs[4];
        ab = '{8'h25, 8'h32, 8'hA2, 8'h44};
        rs = '{8'h25, 8'h32, 8'h22, 8'h45};
        hif.cs = 1'b1; hif.rd = 1'b1; hif.wr = 1'b1; hif.addr = 4'h0;
        hif.databus_in = 8'h00; hif.end_ack = 1'b0;
        core_done = 1'b0; core_result = 32'h0;
        #1 arst = 1'b1;
        cyc(2);
        chk("rst_busy",   {31'h0, hif.busy},    32'h0);
        chk("rst_cmdend", {31'h0, hif.cmd_end}, 32'h0);
        chk("rst_start",  {31'h0, core_start},  32'h0);
        chk("rst_core_a", core_a, 32'h0);
        rd_chk("rst_status", 4'hD, 8'h00);
        arst = 1'b0;
        chk_en = 1'b1;

        // Operand load, readback; first byte held low three cycles.
        wr_byte(4'h0, ab[0], 3);
        for (int i = 1; i < 4; i++) wr_byte(4'(i), ab[i]);
        for (int i = 0; i < 4; i++) wr_byte(4'(i + 4), ab[i]);
        chk("core_a", core_a, 32'h44A23225);
        chk("core_b", core_b, 32'h44A23225);
        for (int i = 0; i < 8; i++) rd_chk("rdback", 4'(i), ab[i % 4]);
        wr_byte(4'h8, 8'h01);
        rd_chk("rd_op", 4'h8, 8'h01);

        // START held low three cycles must start once and leave ovr clear.
        wr_byte(4'h9, 8'h00, 3);
        chk("busy_run", {31'h0, hif.busy}, 32'h1);
        rd_chk("status_run", 4'hD, 8'h01);
        wr_byte(4'h0, 8'hFF);
        chk("core_a_held", core_a, 32'h44A23225);
        rd_chk("status_ovr", 4'hD, 8'h05);
        wr_byte(4'hD, 8'h00);
        rd_chk("status_clr", 4'hD, 8'h01);
        core_done = 1'b1; core_result = 32'h45223225;
        cyc(1);
        core_done = 1'b0;
        chk("done_cmdend", {31'h0, hif.cmd_end}, 32'h1);
        chk("done_busy",   {31'h0, hif.busy},    32'h0);
        for (int i = 0; i < 4; i++) rd_chk("rd_res", 4'(i + 9), rs[i]);

        // end_ack returns to idle; left high, next START is still accepted.
        hif.end_ack = 1'b1;
        cyc(1);
        chk("ack_cmdend", {31'h0, hif.cmd_end}, 32'h0);
        wr_byte(4'h9, 8'h00);
        chk("start_pulse", {31'h0, core_start}, 32'h1);
        chk("start_busy",  {31'h0, hif.busy},   32'h1);
        hif.end_ack = 1'b0;
        n = 1;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (k == 0) chk("start_one", {31'h0, core_start}, 32'h0);
            if (!hif.busy) break;
            n++;
        end
        chk("timeout_len", n, TO);
        chk("to_cmdend", {31'h0, hif.cmd_end}, 32'h1);
        rd_chk("to_r0", 4'h9, 8'h00);
        rd_chk("to_r1", 4'hA, 8'h00);
        rd_chk("to_r2", 4'hB, 8'hC0);
        rd_chk("to_r3", 4'hC, 8'h7F);
        rd_chk("to_status", 4'hD, 8'h06);
        hif.end_ack = 1'b1; cyc(1); hif.end_ack = 1'b0;
        wr_byte(4'hD, 8'h00);

        // Reset mid-run abandons the operation.
        wr_byte(4'h9, 8'h00);
        cyc(2);
        #1 arst = 1'b1;
        #1 arst = 1'b0;
        core_done = 1'b1; core_result = 32'hDEADBEEF;
        cyc(1);
        core_done = 1'b0;
        chk("arst_busy",   {31'h0, hif.busy},    32'h0);
        chk("arst_cmdend", {31'h0, hif.cmd_end}, 32'h0);
        chk("arst_core_a", core_a, 32'h0);
        for (int i = 0; i < 4; i++) rd_chk("arst_res", 4'(i + 9), 8'h00);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            hif.cs = ($urandom_range(0, 3) == 0);
            hif.rd = $urandom_range(0, 1) == 1;
            hif.wr = $urandom_range(0, 2) != 0;
            hif.addr = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 4'h9 : 4'hD)
                                                   : 4'($urandom);
            hif.databus_in = 8'($urandom);
            hif.end_ack = ($urandom_range(0, 3) == 0);
            core_done = ($urandom_range(0, 9) == 0);
            core_result = $urandom;
            cyc(1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
